mem_load_unit: RTL

Load-side memory reader for the pipelined ARM datapath. Accepts one load command from the memory stage, issues a single aligned 64-bit read to data memory, waits a variable number of cycles for the returned data, then extracts and sign- or zero-extends the requested byte, half, word or doubleword. It presents the result to the writeback stage with a one-cycle done strobe. It is the read counterpart of the store path and the register-file write port.

---
 rtl/mem_load_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_load_unit.sv
// ============================================================================
// mem_load_unit : aligned 64-bit load with lane extract, extension and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_start,
  input  logic [63:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [4:0]  ld_rd,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [63:0] ld_data,
  output logic [4:0]  ld_rd_out,
  output logic        wb_en,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [2:0]  off;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [7:0]  cnt;

  logic        misaligned;
  logic        accept_ok;
  logic        accept_bad;
  logic        capture;
  logic        expire;
  logic [63:0] shifted;
  logic [63:0] extended;

  always_comb begin
    case (ld_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ld_addr[0];
      2'd2:    misaligned = |ld_addr[1:0];
      default: misaligned = |ld_addr[2:0];
    endcase
  end

  // Little-endian: byte offset N lives at bits [8N+7:8N] of the dword.
  assign shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    extended = {{56{signed_q & shifted[7]}},  shifted[7:0]};
      2'd1:    extended = {{48{signed_q & shifted[15]}}, shifted[15:0]};
      2'd2:    extended = {{32{signed_q & shifted[31]}}, shifted[31:0]};
      default: extended = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          if (misaligned) begin
            accept_bad = 1'b1;
            state_next = DONE;
          end else begin
            accept_ok  = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: state_next = WAIT;
      WAIT: begin
        // Data arriving on the expiry cycle takes priority over the timeout.
        if (mem_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (cnt == TO_LAST) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      ld_data   <= '0;
      ld_rd_out <= '0;
      wb_en     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      off       <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      cnt       <= '0;
    end else begin
      ld_busy <= (state_next != IDLE);
      ld_done <= (state_next == DONE);
      mem_req <= (state_next == REQ);
      wb_en   <= 1'b0;

      if (accept_ok || accept_bad) ld_rd_out <= ld_rd;

      if (accept_ok) begin
        mem_addr <= {ld_addr[63:3], 3'b000};
        off      <= ld_addr[2:0];
        size_q   <= ld_size;
        signed_q <= ld_signed;
        ld_err   <= 1'b0;
      end

      if (accept_bad || expire) begin
        ld_err  <= 1'b1;
        ld_data <= '0;
      end

      if (state == REQ) cnt <= '0;
      else if (state == WAIT && !mem_rvalid && !expire) cnt <= cnt + 8'd1;

      if (capture) begin
        ld_data <= extended;
        ld_err  <= 1'b0;
        // X31 reads as XZR and is never written back.
        wb_en   <= (ld_rd_out != 5'd31);
      end
    end
  end

endmodule

`default_nettype wire
